// File: rtl/measure_seq_pkg.sv
// Shared constants for the frequency-measurement sequencer: counter register map,
// bus protocol limits, fault codes and FSM state encodings.
package measure_seq_pkg;

    localparam logic [31:0] CNT_BASE    = 32'h0000_0100;
    localparam logic [31:0] OFF_GATE    = 32'h0000_0000;
    localparam logic [31:0] OFF_CTRL    = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;
    localparam logic [31:0] OFF_COARSE  = 32'h0000_000C;
    localparam logic [31:0] OFF_FINE    = 32'h0000_0010;

    localparam logic [7:0]  ACC_TIMEOUT = 8'd255;
    localparam logic [1:0]  MAX_RETRY   = 2'd3;
    localparam logic [4:0]  POLL_GAP    = 5'd16;
    localparam logic [15:0] POLL_MAX    = 16'd65535;

    localparam logic [1:0]  FC_NONE     = 2'd0;
    localparam logic [1:0]  FC_BUS_ERR  = 2'd1;
    localparam logic [1:0]  FC_RETRY    = 2'd2;
    localparam logic [1:0]  FC_TIMEOUT  = 2'd3;

    localparam logic [3:0]  ST_IDLE      = 4'd0;
    localparam logic [3:0]  ST_WR_GATE   = 4'd1;
    localparam logic [3:0]  ST_WR_START  = 4'd2;
    localparam logic [3:0]  ST_POLL_RD   = 4'd3;
    localparam logic [3:0]  ST_POLL_WAIT = 4'd4;
    localparam logic [3:0]  ST_RD_COARSE = 4'd5;
    localparam logic [3:0]  ST_RD_FINE   = 4'd6;
    localparam logic [3:0]  ST_DONE      = 4'd7;
    localparam logic [3:0]  ST_FAULT     = 4'd8;

    function automatic logic [31:0] reg_addr(input logic [31:0] off);
        return CNT_BASE + off;
    endfunction

endpackage

// File: rtl/wb_single_access.sv
// Executes one Wishbone classic access with error/retry/timeout handling and
// reports completion as a one-cycle acc_done with a status code and read data.
module wb_single_access
    import measure_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        we,
    output logic [3:0]  sel,
    output logic        cyc,
    input  logic [31:0] rdata_in,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic        acc_done,
    output logic [1:0]  acc_status,
    output logic [31:0] rdata
);

    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        we_r;
    logic [3:0]  sel_r;
    logic        cyc_r;
    logic        reissue_r;
    logic [7:0]  tmo_cnt_r;
    logic [1:0]  rty_cnt_r;
    logic        done_r;
    logic [1:0]  status_r;
    logic [31:0] rdata_r;

    // Bus cycle control; a retry spends exactly one idle cycle before reissuing the held access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            we_r      <= 1'b0;
            sel_r     <= 4'h0;
            cyc_r     <= 1'b0;
            reissue_r <= 1'b0;
            tmo_cnt_r <= 8'd0;
            rty_cnt_r <= 2'd0;
            done_r    <= 1'b0;
            status_r  <= FC_NONE;
            rdata_r   <= 32'd0;
        end else begin
            done_r <= 1'b0;
            if (cyc_r) begin
                if (err) begin
                    cyc_r    <= 1'b0;
                    done_r   <= 1'b1;
                    status_r <= FC_BUS_ERR;
                end else if (rty) begin
                    cyc_r <= 1'b0;
                    if (rty_cnt_r == MAX_RETRY) begin
                        done_r   <= 1'b1;
                        status_r <= FC_RETRY;
                    end else begin
                        rty_cnt_r <= rty_cnt_r + 2'd1;
                        reissue_r <= 1'b1;
                    end
                end else if (ack) begin
                    cyc_r    <= 1'b0;
                    done_r   <= 1'b1;
                    status_r <= FC_NONE;
                    rdata_r  <= rdata_in;
                end else if (tmo_cnt_r == ACC_TIMEOUT - 8'd1) begin
                    cyc_r    <= 1'b0;
                    done_r   <= 1'b1;
                    status_r <= FC_TIMEOUT;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + 8'd1;
                end
            end else if (reissue_r) begin
                cyc_r     <= 1'b1;
                reissue_r <= 1'b0;
                tmo_cnt_r <= 8'd0;
            end else if (req) begin
                cyc_r     <= 1'b1;
                addr_r    <= req_addr;
                wdata_r   <= req_we ? req_wdata : 32'd0;
                we_r      <= req_we;
                sel_r     <= 4'hF;
                tmo_cnt_r <= 8'd0;
                rty_cnt_r <= 2'd0;
            end else begin
                cyc_r <= 1'b0;
            end
        end
    end

    assign addr       = addr_r;
    assign wdata      = wdata_r;
    assign we         = we_r;
    assign sel        = sel_r;
    assign cyc        = cyc_r;
    assign acc_done   = done_r;
    assign acc_status = status_r;
    assign rdata      = rdata_r;

endmodule

// File: rtl/measure_sequencer.sv
// Second Wishbone master that runs one full gate/start/poll/readback measurement
// on the frequency counter and presents the captured counts.
module measure_sequencer
    import measure_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] gate_i,
    output logic [31:0] addr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        lock_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] coarse_o,
    output logic [31:0] fine_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o
);

    logic [3:0]  state_r;
    logic [15:0] poll_cnt_r;
    logic [4:0]  gap_cnt_r;
    logic [31:0] hold_coarse_r;
    logic        busy_r;
    logic        done_r;
    logic        fault_r;
    logic [1:0]  fault_code_r;
    logic [31:0] coarse_r;
    logic [31:0] fine_r;

    logic        req_s;
    logic [31:0] req_addr_s;
    logic [31:0] req_wdata_s;
    logic        req_we_s;
    logic        cyc_s;
    logic        acc_done_s;
    logic [1:0]  acc_status_s;
    logic [31:0] acc_rdata_s;
    logic        acc_ok_s;
    logic        acc_fail_s;

    assign acc_ok_s   = acc_done_s && (acc_status_s == FC_NONE);
    assign acc_fail_s = acc_done_s && (acc_status_s != FC_NONE);

    // Next access is requested in the same cycle the previous one reports done, keeping one idle gap.
    always_comb begin
        req_s       = 1'b0;
        req_addr_s  = 32'd0;
        req_wdata_s = 32'd0;
        req_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_s       = start_i;
                req_addr_s  = reg_addr(OFF_GATE);
                req_wdata_s = gate_i;
                req_we_s    = 1'b1;
            end
            ST_WR_GATE: begin
                req_s       = acc_ok_s;
                req_addr_s  = reg_addr(OFF_CTRL);
                req_wdata_s = 32'd1;
                req_we_s    = 1'b1;
            end
            ST_WR_START: begin
                req_s      = acc_ok_s;
                req_addr_s = reg_addr(OFF_STATUS);
            end
            ST_POLL_RD: begin
                req_s      = acc_ok_s && acc_rdata_s[0];
                req_addr_s = reg_addr(OFF_COARSE);
            end
            ST_POLL_WAIT: begin
                req_s      = (gap_cnt_r == POLL_GAP - 5'd1);
                req_addr_s = reg_addr(OFF_STATUS);
            end
            ST_RD_COARSE: begin
                req_s      = acc_ok_s;
                req_addr_s = reg_addr(OFF_FINE);
            end
            default: begin
                req_s = 1'b0;
            end
        endcase
    end

    // Sequencing FSM; any failed access overrides the normal state flow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r       <= ST_IDLE;
            poll_cnt_r    <= 16'd0;
            gap_cnt_r     <= 5'd0;
            hold_coarse_r <= 32'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            fault_r       <= 1'b0;
            fault_code_r  <= FC_NONE;
            coarse_r      <= 32'd0;
            fine_r        <= 32'd0;
        end else begin
            done_r  <= 1'b0;
            fault_r <= 1'b0;
            if (acc_fail_s) begin
                state_r      <= ST_FAULT;
                fault_r      <= 1'b1;
                fault_code_r <= acc_status_s;
                busy_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_i) begin
                            busy_r       <= 1'b1;
                            fault_code_r <= FC_NONE;
                            state_r      <= ST_WR_GATE;
                        end
                    end
                    ST_WR_GATE: begin
                        if (acc_ok_s) begin
                            poll_cnt_r <= 16'd0;
                            state_r    <= ST_WR_START;
                        end
                    end
                    ST_WR_START: begin
                        if (acc_ok_s) begin
                            state_r <= ST_POLL_RD;
                        end
                    end
                    ST_POLL_RD: begin
                        if (acc_ok_s) begin
                            if (acc_rdata_s[0]) begin
                                state_r <= ST_RD_COARSE;
                            end else if (poll_cnt_r == POLL_MAX - 16'd1) begin
                                state_r      <= ST_FAULT;
                                fault_r      <= 1'b1;
                                fault_code_r <= FC_TIMEOUT;
                                busy_r       <= 1'b0;
                            end else begin
                                poll_cnt_r <= poll_cnt_r + 16'd1;
                                gap_cnt_r  <= 5'd1;
                                state_r    <= ST_POLL_WAIT;
                            end
                        end
                    end
                    ST_POLL_WAIT: begin
                        if (gap_cnt_r == POLL_GAP - 5'd1) begin
                            state_r <= ST_POLL_RD;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + 5'd1;
                        end
                    end
                    ST_RD_COARSE: begin
                        if (acc_ok_s) begin
                            hold_coarse_r <= acc_rdata_s;
                            state_r       <= ST_RD_FINE;
                        end
                    end
                    ST_RD_FINE: begin
                        if (acc_ok_s) begin
                            coarse_r <= hold_coarse_r;
                            fine_r   <= acc_rdata_s;
                            done_r   <= 1'b1;
                            busy_r   <= 1'b0;
                            state_r  <= ST_DONE;
                        end
                    end
                    ST_DONE:  state_r <= ST_IDLE;
                    ST_FAULT: state_r <= ST_IDLE;
                    default:  state_r <= ST_IDLE;
                endcase
            end
        end
    end

    wb_single_access u_acc (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .req        (req_s),
        .req_addr   (req_addr_s),
        .req_wdata  (req_wdata_s),
        .req_we     (req_we_s),
        .addr       (addr_o),
        .wdata      (dat_o),
        .we         (we_o),
        .sel        (sel_o),
        .cyc        (cyc_s),
        .rdata_in   (dat_i),
        .ack        (ack_i),
        .err        (err_i),
        .rty        (rty_i),
        .acc_done   (acc_done_s),
        .acc_status (acc_status_s),
        .rdata      (acc_rdata_s)
    );

    assign cyc_o        = cyc_s;
    assign stb_o        = cyc_s;
    assign lock_o       = 1'b0;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign fault_o      = fault_r;
    assign fault_code_o = fault_code_r;
    assign coarse_o     = coarse_r;
    assign fine_o       = fine_r;

endmodule

// File: tb/tb_measure_sequencer.sv
// Directed bench for measure_sequencer with a scripted Wishbone counter slave.
`timescale 1ns/1ps
module tb_measure_sequencer;

    localparam logic [31:0] A_GATE   = 32'h0000_0100;
    localparam logic [31:0] A_CTRL   = 32'h0000_0104;
    localparam logic [31:0] A_STATUS = 32'h0000_0108;
    localparam logic [31:0] A_COARSE = 32'h0000_010C;
    localparam logic [31:0] A_FINE   = 32'h0000_0110;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] gate_i  = 32'd0;
    logic [31:0] addr_o, dat_o, dat_i, coarse_o, fine_o;
    logic        we_o, cyc_o, stb_o, lock_o, ack_i, err_i, rty_i;
    logic        busy_o, done_o, fault_o;
    logic [3:0]  sel_o;
    logic [1:0]  fault_code_o;

    int n_checks = 0;
    int n_errors = 0;

    int cfg_status_after = 1;
    int cfg_gate_rty     = 0;
    int cfg_coarse_rty   = 0;
    bit cfg_ctrl_err     = 1'b0;
    bit cfg_hang_status  = 1'b0;
    bit cfg_hang_fine    = 1'b0;

    bit clr = 1'b0;
    int n_log = 0;
    int status_reads = 0;
    int gate_rty_seen = 0;
    int coarse_rty_seen = 0;
    int cyc_n = 0;
    bit excl_bad = 1'b0;
    bit fault_seen = 1'b0;
    logic [31:0] log_addr [64];
    logic [31:0] log_dat  [64];
    logic        log_we   [64];
    logic [3:0]  log_sel  [64];
    int          log_t    [64];

    measure_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .gate_i(gate_i),
        .addr_o(addr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .lock_o(lock_o), .ack_i(ack_i), .err_i(err_i),
        .rty_i(rty_i), .busy_o(busy_o), .done_o(done_o), .coarse_o(coarse_o),
        .fine_o(fine_o), .fault_o(fault_o), .fault_code_o(fault_code_o)
    );

    always #5 clk_i = ~clk_i;

    // Zero-wait counter slave whose terminations are scripted by the cfg_* knobs.
    always_comb begin
        ack_i = 1'b0;
        err_i = 1'b0;
        rty_i = 1'b0;
        dat_i = 32'd0;
        if (cyc_o && stb_o) begin
            case (addr_o)
                A_GATE: begin
                    rty_i = (gate_rty_seen < cfg_gate_rty);
                    ack_i = !rty_i;
                end
                A_CTRL: begin
                    ack_i = 1'b1;
                    err_i = cfg_ctrl_err;
                end
                A_STATUS: begin
                    ack_i = !cfg_hang_status;
                    dat_i = (status_reads + 1 >= cfg_status_after) ? 32'd1 : 32'd0;
                end
                A_COARSE: begin
                    rty_i = (coarse_rty_seen < cfg_coarse_rty);
                    ack_i = !rty_i;
                    dat_i = 32'hDEAD_BEEF;
                end
                A_FINE: begin
                    ack_i = !cfg_hang_fine;
                    dat_i = 32'h0000_1234;
                end
                default: ack_i = 1'b1;
            endcase
        end
    end

    // Bus monitor: logs every terminated access and tracks pulse exclusivity.
    always @(posedge clk_i) begin
        cyc_n <= cyc_n + 1;
        if ((done_o && (fault_o || busy_o)) || (fault_o && busy_o)) excl_bad <= 1'b1;
        if (clr) begin
            n_log <= 0;
            status_reads <= 0;
            gate_rty_seen <= 0;
            coarse_rty_seen <= 0;
            fault_seen <= 1'b0;
        end else begin
            if (fault_o) fault_seen <= 1'b1;
            if (cyc_o && stb_o && (ack_i || err_i || rty_i)) begin
                if (n_log < 64) begin
                    log_addr[n_log] <= addr_o;
                    log_dat[n_log]  <= dat_o;
                    log_we[n_log]   <= we_o;
                    log_sel[n_log]  <= sel_o;
                    log_t[n_log]    <= cyc_n;
                end
                n_log <= n_log + 1;
                if (addr_o == A_STATUS && ack_i) status_reads <= status_reads + 1;
                if (addr_o == A_GATE && rty_i) gate_rty_seen <= gate_rty_seen + 1;
                if (addr_o == A_COARSE && rty_i) coarse_rty_seen <= coarse_rty_seen + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int st_after, input int g_rty, input int c_rty,
                           input bit c_err, input bit h_st, input bit h_fine);
        cfg_status_after = st_after;
        cfg_gate_rty     = g_rty;
        cfg_coarse_rty   = c_rty;
        cfg_ctrl_err     = c_err;
        cfg_hang_status  = h_st;
        cfg_hang_fine    = h_fine;
        @(negedge clk_i) clr = 1'b1;
        @(negedge clk_i) clr = 1'b0;
    endtask

    task automatic start_seq(input logic [31:0] g, output int t0);
        @(negedge clk_i);
        gate_i  = g;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        t0 = cyc_n;
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("fault_code_cleared", 32'(fault_code_o), 32'd0);
    endtask

    task automatic wait_end(input int bound, output int t_end, output bit is_done, output bit is_fault);
        t_end = -1;
        is_done = 1'b0;
        is_fault = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_i);
            if (done_o || fault_o) begin
                is_done  = done_o;
                is_fault = fault_o;
                t_end    = cyc_n;
                break;
            end
        end
        check("sequence_ended", 32'(t_end >= 0), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cyc"}, 32'(cyc_o), 32'd0);
        check({tag, "_stb"}, 32'(stb_o), 32'd0);
        check({tag, "_we"}, 32'(we_o), 32'd0);
        check({tag, "_lock"}, 32'(lock_o), 32'd0);
        check({tag, "_addr"}, addr_o, 32'd0);
        check({tag, "_dat"}, dat_o, 32'd0);
        check({tag, "_sel"}, 32'(sel_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_fault"}, 32'(fault_o), 32'd0);
        check({tag, "_coarse"}, coarse_o, 32'd0);
        check({tag, "_fine"}, fine_o, 32'd0);
        check({tag, "_fcode"}, 32'(fault_code_o), 32'd0);
    endtask

    initial begin
        int t0;
        int te;
        bit d;
        bit f;
        int run;

        repeat (3) @(negedge clk_i);
        check_reset_values("reset");
        rst_i = 1'b1;
        @(negedge clk_i);

        // Best case: first STATUS read reports done.
        set_cfg(1, 0, 0, 1'b0, 1'b0, 1'b0);
        start_seq(32'd50, t0);
        wait_end(100, te, d, f);
        check("best_done", 32'(d), 32'd1);
        check("best_latency", 32'(te - t0), 32'd10);
        check("best_naccess", 32'(n_log), 32'd5);

        // Nominal: done on third poll, 16 idle cycles between STATUS reads.
        set_cfg(3, 0, 0, 1'b0, 1'b0, 1'b0);
        start_seq(32'd1000, t0);
        wait_end(200, te, d, f);
        check("nom_done", 32'(d), 32'd1);
        check("nom_busy_at_done", 32'(busy_o), 32'd0);
        check("nom_latency", 32'(te - t0), 32'd44);
        check("nom_coarse", coarse_o, 32'hDEAD_BEEF);
        check("nom_fine", fine_o, 32'h0000_1234);
        check("nom_naccess", 32'(n_log), 32'd7);
        check("nom_gate_addr", log_addr[0], A_GATE);
        check("nom_gate_dat", log_dat[0], 32'd1000);
        check("nom_gate_we", 32'(log_we[0]), 32'd1);
        check("nom_ctrl_addr", log_addr[1], A_CTRL);
        check("nom_ctrl_dat", log_dat[1], 32'd1);
        check("nom_ctrl_gap", 32'(log_t[1] - log_t[0]), 32'd2);
        for (int i = 2; i < 5; i++) begin
            check("nom_status_addr", log_addr[i], A_STATUS);
            check("nom_status_we", 32'(log_we[i]), 32'd0);
            check("nom_status_dat", log_dat[i], 32'd0);
        end
        check("nom_poll_gap1", 32'(log_t[3] - log_t[2]), 32'd17);
        check("nom_poll_gap2", 32'(log_t[4] - log_t[3]), 32'd17);
        check("nom_coarse_addr", log_addr[5], A_COARSE);
        check("nom_fine_addr", log_addr[6], A_FINE);
        for (int i = 0; i < 7; i++) check("nom_sel", 32'(log_sel[i]), 32'hF);
        check("nom_no_fault", 32'(fault_seen), 32'd0);
        @(negedge clk_i);
        check("nom_done_pulse", 32'(done_o), 32'd0);
        check("nom_coarse_held", coarse_o, 32'hDEAD_BEEF);

        // Two retries on COARSE, then success.
        set_cfg(1, 0, 2, 1'b0, 1'b0, 1'b0);
        start_seq(32'd77, t0);
        wait_end(100, te, d, f);
        check("rty_done", 32'(d), 32'd1);
        check("rty_fault", 32'(fault_seen), 32'd0);
        check("rty_latency", 32'(te - t0), 32'd14);
        check("rty_naccess", 32'(n_log), 32'd7);
        check("rty_addr1", log_addr[4], A_COARSE);
        check("rty_addr2", log_addr[5], A_COARSE);
        check("rty_reissue_gap", 32'(log_t[4] - log_t[3]), 32'd2);
        check("rty_coarse", coarse_o, 32'hDEAD_BEEF);

        // Retries exhausted on GATE write.
        set_cfg(1, 100, 0, 1'b0, 1'b0, 1'b0);
        start_seq(32'd33, t0);
        wait_end(100, te, d, f);
        check("rex_fault", 32'(f), 32'd1);
        check("rex_done", 32'(d), 32'd0);
        check("rex_code", 32'(fault_code_o), 32'd2);
        check("rex_latency", 32'(te - t0), 32'd8);
        check("rex_last_addr", log_addr[3], A_GATE);
        check("rex_last_dat", log_dat[3], 32'd33);
        repeat (10) @(negedge clk_i);
        check("rex_no_ctrl", 32'(n_log), 32'd4);
        check("rex_code_held", 32'(fault_code_o), 32'd2);
        check("rex_coarse_kept", coarse_o, 32'hDEAD_BEEF);

        // err_i and ack_i together on CTRL write.
        set_cfg(1, 0, 0, 1'b1, 1'b0, 1'b0);
        start_seq(32'd5, t0);
        wait_end(100, te, d, f);
        check("err_fault", 32'(f), 32'd1);
        check("err_code", 32'(fault_code_o), 32'd1);
        check("err_busy_at_fault", 32'(busy_o), 32'd0);
        check("err_latency", 32'(te - t0), 32'd4);
        @(negedge clk_i);
        check("err_busy_after", 32'(busy_o), 32'd0);
        check("err_fault_pulse", 32'(fault_o), 32'd0);
        check("err_naccess", 32'(n_log), 32'd2);

        // STATUS read never terminates; a start during the sequence is ignored.
        set_cfg(1, 0, 0, 1'b0, 1'b1, 1'b0);
        start_seq(32'd9, t0);
        run = 0;
        for (int i = 0; i < 50; i++) begin
            if (stb_o && addr_o == A_STATUS) break;
            @(negedge clk_i);
        end
        gate_i = 32'd7;
        for (int i = 0; i < 400; i++) begin
            if (!stb_o) break;
            run++;
            start_i = (run == 50);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        check("tmo_stb_cycles", 32'(run), 32'd255);
        wait_end(10, te, d, f);
        check("tmo_fault", 32'(f), 32'd1);
        check("tmo_code", 32'(fault_code_o), 32'd3);
        check("tmo_latency", 32'(te - t0), 32'd260);
        repeat (5) @(negedge clk_i);
        check("tmo_start_ignored", 32'(n_log), 32'd2);
        check("tmo_idle_cyc", 32'(cyc_o), 32'd0);

        // Reset in the middle of the FINE read.
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        set_cfg(1, 0, 0, 1'b0, 1'b0, 1'b1);
        start_seq(32'd21, t0);
        for (int i = 0; i < 50; i++) begin
            if (stb_o && addr_o == A_FINE) break;
            @(negedge clk_i);
        end
        check("rst_reached_fine", 32'(stb_o && addr_o == A_FINE), 32'd1);
        check("rst_coarse_before", coarse_o, 32'd0);
        #2 rst_i = 1'b0;
        #1 check_reset_values("rst_mid");
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("rst_after_cyc", 32'(cyc_o), 32'd0);
        check("rst_after_coarse", coarse_o, 32'd0);
        check("rst_after_busy", 32'(busy_o), 32'd0);

        check("pulse_exclusivity", 32'(excl_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/measure_sequencer.md
# measure_sequencer

Wishbone master that runs one complete frequency measurement on the frequency counter slave without software involvement. On a start pulse it programs the gate time, starts the counter, polls status until done, then reads back the coarse and fine counts. Both counts are presented on output ports. It sits on the shared Wishbone bus as a second master, alongside the control unit, behind the bus arbiter.

## Interface
- `CNT_BASE`, 32'h0000_0100: counter slave base address. Register offsets:
  - GATE +0x0
  - CTRL +0x4 (bit0 = start)
  - STATUS +0x8 (bit0 = done)
  - COARSE +0xC
  - FINE +0x10
- `ACC_TIMEOUT`, 255: maximum cycles `stb_o` may stay high waiting for a termination.
- `MAX_RETRY`, 3: retries allowed per access on `rty_i`.
- `POLL_GAP`, 16: idle cycles between STATUS reads.
- `POLL_MAX`, 65535: STATUS reads before declaring a timeout.
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle request; ignored while `busy_o`.
- `gate_i` in 32: gate length, latched on an accepted start.
- `addr_o` out 32, `dat_o` out 32, `dat_i` in 32, `we_o` out 1, `sel_o` out 4, `cyc_o` out 1, `stb_o` out 1, `lock_o` out 1, `ack_i` in 1, `err_i` in 1, `rty_i` in 1: Wishbone classic master.
- `busy_o` out 1: a sequence is in progress.
- `done_o` out 1: one-cycle pulse; the count outputs are valid.
- `coarse_o` out 32, `fine_o` out 32: last captured counts, held until the next done.
- `fault_o` out 1: one-cycle pulse on abort.
- `fault_code_o` out 2: fault cause.
  - 0 = none
  - 1 = bus error
  - 2 = retries exhausted
  - 3 = timeout

## Operation
- **States:** IDLE → WR_GATE → WR_START → POLL_RD → (POLL_GAP wait → POLL_RD)* → RD_COARSE → RD_FINE → DONE → IDLE. Any access failure goes to FAULT → IDLE.
- **IDLE:** on `start_i`, latch `gate_i`, set `busy_o`, clear `fault_code_o`.
- **WR_GATE:** write the latched gate to GATE.
- **WR_START:** write 32'h1 to CTRL.
- **POLL_RD:** read STATUS. If bit0 = 1, go to RD_COARSE. If bit0 = 0, wait `POLL_GAP` cycles and re-read. After `POLL_MAX` reads that return 0, FAULT with code 3.
- **RD_COARSE / RD_FINE:** capture `dat_i` into internal holding registers.
- **DONE:** copy the holding registers to `coarse_o`/`fine_o`, pulse `done_o`, clear `busy_o`.
- **FAULT:** pulse `fault_o`, hold `fault_code_o` until the next accepted start, clear `busy_o`. `coarse_o`/`fine_o` keep their previous values.
- **Every access:**
  - `sel_o` = 4'hF, `lock_o` = 0.
  - `we_o` = 1 only for GATE/CTRL.
  - `dat_o` = 0 during reads.
- **Termination priority when several arrive together:** `err_i` > `rty_i` > `ack_i`.
  - `err_i` → FAULT, code 1.
  - `rty_i` → drop `cyc_o`/`stb_o` for one cycle and reissue the same access. On the (`MAX_RETRY`+1)th `rty_i` → FAULT, code 2.
  - `stb_o` high for `ACC_TIMEOUT` cycles with no termination → drop `cyc_o`/`stb_o` → FAULT, code 3.

## Timing
- **Reset values:**
  - `cyc_o` = `stb_o` = `we_o` = `lock_o` = 0
  - `addr_o` = `dat_o` = 0, `sel_o` = 0
  - `busy_o` = `done_o` = `fault_o` = 0
  - `coarse_o` = `fine_o` = 0, `fault_code_o` = 0
  - State = IDLE
- **Reset mid-access:** `cyc_o`/`stb_o` fall immediately (asynchronous); no partial results are written.
- **Start:** `start_i` is sampled at edge T. `cyc_o`/`stb_o`/`addr_o` are registered and high from T+1.
- **Bus cycle:** `cyc_o` and `stb_o` always rise and fall together. An access terminates at the first edge where `ack_i`, `err_i` or `rty_i` is sampled high. Read data is captured at that same edge. `cyc_o`/`stb_o` are low in the following cycle.
- **Gaps:** at least one idle cycle (`cyc_o` = 0) between consecutive accesses, including retries.
- **Best case:** zero-wait slave, done on the first poll. `done_o` pulses at T+11 (five 1-cycle accesses plus idle gaps and the DONE state).
- **Poll timing:** the gap between STATUS reads is exactly `POLL_GAP` idle cycles, counted from the cycle after termination.
- **Counters:** the timeout counter resets on every new access, including retries. The retry counter resets on every new access except retries. The poll counter resets on WR_START.
- **Pulse exclusivity:** `done_o` and `fault_o` are never high together and are never high while `busy_o` = 1.

## Structure
- **`measure_seq_pkg`:** holds the state enum, register offset constants, and fault code constants.
- **`wb_single_access`:** the natural sub-module. It performs one Wishbone access with the timeout/retry/error rules above and returns a one-cycle `acc_done` plus a status code and read data. The top-level FSM only sequences addresses and data.

## Test plan
- **Nominal:** zero-wait slave, gate 32'd1000, STATUS returns 1 on the third read, COARSE = 32'hDEAD_BEEF, FINE = 32'h0000_1234 → GATE write of 1000, then CTRL write of 1, three STATUS reads spaced by 16 idle cycles, `done_o` pulse, outputs equal those values.
- **Retry:** `rty_i` twice on the COARSE read, then `ack_i` → access reissued at the same address, sequence completes, `fault_o` = 0.
- **Retries exhausted:** `rty_i` four times on the GATE write → FAULT, `fault_code_o` = 2, no CTRL access issued.
- **Error priority:** `err_i` and `ack_i` asserted together on the CTRL write → `fault_code_o` = 1, `busy_o` low one cycle after `fault_o`.
- **Access timeout:** slave never terminates the STATUS read → `stb_o` drops after 255 cycles, `fault_code_o` = 3. A `start_i` during the sequence is ignored.
- **Reset mid-access:** assert `rst_i` = 0 during the FINE read → `cyc_o`/`stb_o` low without a clock edge, all outputs at reset values, `coarse_o` unchanged at 0.
